// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - load/run/drain sequencer around the pseudo_softmax core
// Define SOFTMAX_ARGMAX_EN to add the argmax output port and its tracking logic.
module softmax_seq_ctrl #(
  parameter int N_ELEM   = 4,
  parameter int DW       = 3,
  parameter int CORE_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] core_in,
  input  logic [2:0]    core_mant,
  input  logic [2:0]    core_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_mant,
  output logic [2:0]    out_exp,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          busy
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [2:0]    argmax
`endif
);
  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  localparam logic [3:0] RC_LAST  = 4'(N_ELEM - 1 + CORE_LAT);
  localparam logic [2:0] IDX_LAST = 3'(N_ELEM - 1);

  state_t        state;
  logic [2:0]    ld_cnt;
  logic [3:0]    rc;
  logic [DW-1:0] max_r;
  logic [DW-1:0] elem     [8];
  logic [2:0]    res_mant [8];
  logic [2:0]    res_exp  [8];
  logic [2:0]    cap_idx;
  logic [2:0]    nxt_idx;
  logic [2:0]    rc_idx;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign cap_idx  = 3'(rc - 4'(CORE_LAT));
  assign nxt_idx  = out_idx + 3'd1;
  assign rc_idx   = rc[2:0];

  // Driven straight from registers so a zero-latency core sees it in the same rc cycle.
  assign core_in = (state == RUN && rc < 4'(N_ELEM)) ? (max_r - elem[rc_idx]) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= LOAD;
      ld_cnt    <= '0;
      rc        <= '0;
      max_r     <= '0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        elem[i]     <= '0;
        res_mant[i] <= '0;
        res_exp[i]  <= '0;
      end
`ifdef SOFTMAX_ARGMAX_EN
      argmax <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            elem[ld_cnt] <= in_data;
            // First accept reloads the max so a stale value from the last vector cannot win.
            if (ld_cnt == '0 || in_data > max_r) begin
              max_r <= in_data;
`ifdef SOFTMAX_ARGMAX_EN
              argmax <= ld_cnt;
`endif
            end
            if (ld_cnt == IDX_LAST) begin
              ld_cnt <= '0;
              rc     <= '0;
              state  <= RUN;
            end else begin
              ld_cnt <= ld_cnt + 3'd1;
            end
          end
        end
        RUN: begin
          if (int'(rc) >= CORE_LAT) begin
            res_mant[cap_idx] <= core_mant;
            res_exp[cap_idx]  <= core_exp;
          end
          if (rc == RC_LAST) begin
            rc        <= '0;
            state     <= OUT;
            out_valid <= 1'b1;
            out_mant  <= res_mant[0];
            out_exp   <= res_exp[0];
            out_idx   <= '0;
            out_last  <= 1'b0;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_mant  <= '0;
              out_exp   <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= nxt_idx;
              out_mant <= res_mant[nxt_idx];
              out_exp  <= res_exp[nxt_idx];
              out_last <= (nxt_idx == IDX_LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
